// File: rtl/serial_xmtr_if.sv
// serial_xmtr_if: byte handshake in, serial frame status out (din/valid/ready, sdata/busy/tx_done)
interface serial_xmtr_if;
  logic [7:0] din;
  logic valid;
  logic ready;
  logic sdata;
  logic busy;
  logic tx_done;
  modport master (output din, valid, input ready, sdata, busy, tx_done);
  modport slave (input din, valid, output ready, sdata, busy, tx_done);
endinterface

// File: rtl/serial_xmtr.sv
// serial_xmtr: double-buffered header-framed serialiser; ports clk, rst_n (async low), bus (din/valid/ready in, sdata/busy/tx_done out)
module serial_xmtr #(
  parameter int HEADER_SIZE = 8,
  parameter logic [HEADER_SIZE-1:0] HEADER_VALUE = 8'hA5,
  parameter int BODY_SIZE = 16,
  parameter logic IDLE_BIT = 1'b0
) (
  input logic clk,
  input logic rst_n,
  serial_xmtr_if.slave bus
);
  localparam int TOT = HEADER_SIZE + BODY_SIZE;
  localparam int NB = BODY_SIZE / 8;
  localparam int CW = $clog2(TOT + 1);
  localparam int NW = $clog2(NB + 1);
  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;
  state_t state, state_nx;
  logic [BODY_SIZE-1:0] body;
  logic [NW-1:0] cnt;
  logic [TOT-1:0] sh;
  logic [CW-1:0] bc;
  logic full, last, load, accept;
  assign full = cnt == NW'(NB);
  assign last = bc == CW'(TOT - 1);
  // a full buffer is taken when idle or exactly as the last body bit ends (zero gap)
  assign load = full && (state == IDLE || (state == BODY && last));
  assign accept = bus.valid && !full;
  always_comb begin
    state_nx = load ? HDR :
               (state == HDR && bc == CW'(HEADER_SIZE - 1)) ? BODY :
               (state == BODY && last) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      body <= '0;
      cnt <= '0;
      sh <= '0;
      bc <= '0;
    end else if (load) begin
      sh <= {HEADER_VALUE, body};
      bc <= '0;
      body <= '0;
      cnt <= '0;
    end else begin
      if (state != IDLE) begin
        sh <= sh << 1;
        bc <= bc + 1'b1;
      end
      // bytes shift in from the bottom so the first one ends up most significant
      if (accept) begin
        body <= BODY_SIZE'({body, bus.din});
        cnt <= cnt + 1'b1;
      end
    end
  assign bus.ready = !full;
  assign bus.busy = state != IDLE;
  assign bus.sdata = (state != IDLE) ? sh[TOT-1] : IDLE_BIT;
  assign bus.tx_done = state == BODY && last;
endmodule

// File: tb/tb_serial_xmtr.sv
// tb_serial_xmtr: directed stimulus with a queue-based frame model and literal frame checks
module tb_serial_xmtr;
  logic clk = 0;
  logic rst_n;
  always #5 clk = ~clk;
  serial_xmtr_if bus();
  serial_xmtr dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int total = 0, passed = 0;
  task automatic chk(input string n, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  // model: collected bytes and the bits of the frame currently on the line
  bit fq[$];
  int mcnt = 0;
  logic [15:0] mbody = '0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fq = {};
      mcnt = 0;
      mbody = '0;
    end else begin
      bit acc;
      logic [23:0] fr;
      acc = bus.valid && mcnt < 2;
      if (mcnt == 2 && fq.size() <= 1) begin
        fr = {8'hA5, mbody};
        fq = {};
        for (int i = 23; i >= 0; i--) fq.push_back(fr[i]);
        mcnt = 0;
        mbody = '0;
      end else begin
        if (fq.size() > 0) void'(fq.pop_front());
        if (acc) begin
          mbody = {mbody[7:0], bus.din};
          mcnt++;
        end
      end
    end
  always @(negedge clk) begin
    chk("sdata", 72'(bus.sdata), 72'(fq.size() > 0 ? fq[0] : 1'b0));
    chk("busy", 72'(bus.busy), 72'(fq.size() > 0));
    chk("tx_done", 72'(bus.tx_done), 72'(fq.size() == 1));
    chk("ready", 72'(bus.ready), 72'(mcnt < 2));
  end
  // receive model: hunts for the header and gathers the body bytes
  bit rx_on = 0;
  logic [7:0] sr = '0;
  logic [15:0] rx_body = '0;
  int rx_n = 0;
  logic [7:0] rxq[$];
  always @(negedge clk)
    if (rx_on) begin
      if (rx_n == 0) begin
        sr = {sr[6:0], bus.sdata};
        if (sr == 8'hA5) rx_n = 16;
      end else begin
        rx_body = {rx_body[14:0], bus.sdata};
        rx_n--;
        if (rx_n == 0) begin
          rxq.push_back(rx_body[15:8]);
          rxq.push_back(rx_body[7:0]);
          sr = '0;
        end
      end
    end
  task automatic send(input logic [7:0] b);
    bit r;
    int i;
    bus.valid = 1;
    for (i = 0; i < 300; i++) begin
      r = bus.ready;
      bus.din = r ? b : 8'($urandom);
      @(negedge clk);
      if (r) break;
    end
    if (i == 300) chk("send_timeout", 0, 1);
  endtask
  task automatic capture(input int n, input logic [71:0] exp, input logic [71:0] tdx, input string name);
    logic [71:0] bits = '0, td = '0;
    int bc = 0, k = 0;
    while (!bus.busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < n; i++) begin
      bits = {bits[70:0], bus.sdata};
      td = {td[70:0], bus.tx_done};
      bc += int'(bus.busy);
      @(negedge clk);
    end
    chk({name, "_bits"}, bits, exp);
    chk({name, "_txdone"}, td, tdx);
    chk({name, "_busy_cycles"}, 72'(bc), 72'(n));
    chk({name, "_idle_after"}, {bus.busy, bus.sdata}, 0);
  endtask
  initial begin
    logic [7:0] rb[8];
    int k;
    rst_n = 0;
    bus.valid = 0;
    bus.din = 0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {bus.sdata, bus.busy, bus.ready, bus.tx_done}, 4'b0010);
    rst_n = 1;
    @(negedge clk);
    fork
      begin send(8'h3C); send(8'hF0); bus.valid = 0; end
      capture(24, 72'hA53CF0, 72'h1, "single");
    join
    fork
      begin send(8'h11); send(8'h22); send(8'h33); send(8'h44); bus.valid = 0; end
      capture(48, 72'hA51122A53344, 72'h000001000001, "b2b");
    join
    fork
      begin for (int i = 1; i <= 6; i++) send(8'(i)); bus.valid = 0; end
      capture(72, 72'hA50102A50304A50506, 72'h000001000001000001, "flow");
    join
    send(8'h77);
    bus.valid = 0;
    repeat (30) @(negedge clk);
    chk("partial_wait", {bus.busy, bus.sdata}, 0);
    fork
      begin send(8'h88); bus.valid = 0; end
      capture(24, 72'hA57788, 72'h1, "partial");
    join
    send(8'hC1);
    send(8'hC2);
    send(8'hC3);
    bus.valid = 0;
    k = 0;
    while (!bus.tx_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("gap_txdone_seen", 72'(bus.tx_done), 1);
    send(8'hC4);
    bus.valid = 0;
    chk("gap_idle", {bus.busy, bus.sdata}, 0);
    @(negedge clk);
    chk("gap_restart", {bus.busy, bus.sdata}, 2'b11);
    repeat (30) @(negedge clk);
    send(8'hD1);
    send(8'hD2);
    bus.valid = 0;
    repeat (6) @(negedge clk);
    chk("midframe_busy", 72'(bus.busy), 1);
    #2 rst_n = 0;
    #1 chk("midframe_rst", {bus.sdata, bus.busy, bus.ready, bus.tx_done}, 4'b0010);
    @(negedge clk);
    rst_n = 1;
    repeat (30) @(negedge clk);
    chk("no_resume", {bus.busy, bus.sdata}, 0);
    rxq = {};
    sr = '0;
    rx_n = 0;
    rx_on = 1;
    void'($urandom(42));
    foreach (rb[i]) rb[i] = 8'($urandom);
    foreach (rb[i]) send(rb[i]);
    bus.valid = 0;
    k = 0;
    while (rxq.size() < 8 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("loop_count", 72'(rxq.size()), 8);
    foreach (rb[i]) chk("loop_byte", 72'(i < rxq.size() ? rxq[i] : 8'hxx), 72'(rb[i]));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
